// File: rtl/pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_sequencer : Hack CPU fetch/execute controller (boot, halt, step, stall)
// Revision 1.0
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  input  logic        zr,
  input  logic        ng,
  input  logic        mem_busy,
  output logic        rom_req,
  output logic [15:0] instr,
  output logic        exec_en,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    HALT  = 2'd1,
    FETCH = 2'd2,
    EXEC  = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state;
  logic [3:0] boot_cnt;
  logic       step_flag;
  logic       commit;
  logic       jump;

  assign pc_reset = reset | (state == BOOT);
  assign commit   = ~reset & (state == EXEC) & ~mem_busy;
  assign jump     = instr[15] & ((instr[2] & ng) | (instr[1] & zr) |
                                 (instr[0] & ~ng & ~zr));
  assign exec_en  = commit;
  assign pc_load  = commit & jump;
  assign pc_inc   = commit & ~jump;

  // rom_req and halted are registered from the next-state decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      boot_cnt  <= 4'd0;
      instr     <= 16'h0000;
      rom_req   <= 1'b0;
      halted    <= 1'b0;
      retired   <= 16'h0000;
      step_flag <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 4'd1;
          if (boot_cnt == BOOT_LAST) begin
            if (run) begin
              state   <= FETCH;
              rom_req <= 1'b1;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          if (run) begin
            state   <= FETCH;
            rom_req <= 1'b1;
            halted  <= 1'b0;
          end else if (step) begin
            state     <= FETCH;
            rom_req   <= 1'b1;
            halted    <= 1'b0;
            step_flag <= 1'b1;
          end
        end
        FETCH: begin
          if (rom_ack) begin
            instr   <= rom_data;
            state   <= EXEC;
            rom_req <= 1'b0;
          end
        end
        EXEC: begin
          if (!mem_busy) begin
            retired <= retired + 16'd1;
            if (run && !step_flag) begin
              state   <= FETCH;
              rom_req <= 1'b1;
            end else begin
              state     <= HALT;
              halted    <= 1'b1;
              step_flag <= 1'b0;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute controller for the Hack CPU. It drives the program counter's `reset`, `load` and `inc` strobes and handshakes instruction fetches with the instruction ROM. It latches the current instruction, resolves C-instruction jump conditions from the ALU flags, and stalls on data-memory busy. It sits between the ROM, the program counter and the CPU datapath, and provides run/halt/single-step control.

## Interface
- `BOOT_CYCLES`, default 2: cycles the PC is held in reset after `reset` deasserts (1..15).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  level; 1 = execute continuously, 0 = stop after the current instruction.
- `step`  in  1  one-cycle pulse; executes exactly one instruction when halted.
- `rom_ack`  in  1  ROM data valid on `rom_data` this cycle.
- `rom_data`  in  16  instruction word from ROM.
- `zr`  in  1  ALU zero flag for the instruction in EXEC.
- `ng`  in  1  ALU negative flag for the instruction in EXEC.
- `mem_busy`  in  1  data memory not ready; blocks commit.
- `rom_req`  out  1  fetch request.
- `instr`  out  16  latched current instruction.
- `exec_en`  out  1  commit strobe; CPU register/memory writes are allowed only when this is high.
- `pc_reset`  out  1  to program counter `reset`.
- `pc_load`  out  1  to program counter `load`; the PC takes the A register.
- `pc_inc`  out  1  to program counter `inc`.
- `halted`  out  1  controller is in HALT.
- `retired`  out  16  count of committed instructions.

## Operation
- States:
  - BOOT: hold the PC in reset for `BOOT_CYCLES`.
  - HALT: idle.
  - FETCH: `rom_req`=1 until `rom_ack`.
  - EXEC: execute the latched instruction.
- Reset values: state=BOOT, boot counter=0, `instr`=0x0000, `rom_req`=0, `exec_en`=0, `pc_load`=0, `pc_inc`=0, `halted`=0, `retired`=0, single-step flag=0.
- `pc_reset` = `reset` OR (state==BOOT). It is combinational so the PC clears asynchronously with `reset`.
- BOOT: the counter increments each cycle. At `BOOT_CYCLES`-1 the next state is FETCH if `run`=1, else HALT.
- HALT: `halted`=1.
  - `run`=1 → FETCH.
  - Otherwise `step`=1 → FETCH and set the single-step flag.
- FETCH: `rom_req`=1. On a cycle with `rom_ack`=1, `instr`←`rom_data` and the next state is EXEC. `rom_ack` is ignored in all other states.
- EXEC:
  - Commit = (state==EXEC) AND NOT `mem_busy`. `exec_en`=commit.
  - While `mem_busy`=1: stay in EXEC, all PC strobes 0.
  - Jump = `instr[15]` AND ((`instr[2]` AND `ng`) OR (`instr[1]` AND `zr`) OR (`instr[0]` AND NOT `ng` AND NOT `zr`)). A-instructions (`instr[15]`=0) never jump.
  - On commit: `pc_load`=jump, `pc_inc`=NOT jump (never both high), and `retired`+1, wrapping 0xFFFF→0x0000.
  - After commit: next state is FETCH if `run`=1 and the single-step flag is clear. Otherwise the next state is HALT and the single-step flag clears.
- `zr` and `ng` are sampled only in the commit cycle.
- `run` falling mid-instruction: the instruction completes normally, then HALT.
- `step` outside HALT is ignored. `step` and `run` together in HALT are treated as run.
- `pc_load`, `pc_inc` and `exec_en` are combinational from state and inputs. The PC updates on the same edge that leaves EXEC.

## Timing
- Minimum 2 cycles per instruction: FETCH with immediate `rom_ack`, then EXEC with `mem_busy`=0.
- Each cycle of `rom_ack` delay adds one FETCH cycle. Each cycle of `mem_busy` adds one EXEC cycle.
- First `rom_req` occurs `BOOT_CYCLES` cycles after `reset` falls, given `run`=1.
- Asserting `reset` in any state forces the following immediately (asynchronously):
  - `rom_req`, `exec_en`, `pc_load` and `pc_inc` go to 0.
  - `pc_reset` goes to 1.
  - Any in-flight fetch is abandoned; a late `rom_ack` is ignored.

## Test plan
- Reset/boot: with `BOOT_CYCLES`=2 and `run`=0, release `reset` → `pc_reset`=1 for 2 cycles, then `halted`=1, `rom_req`=0, `retired`=0.
- A-instruction: `run`=1, `rom_data`=0x0005 acked in the first FETCH cycle → next cycle `instr`=0x0005, `exec_en`=1, `pc_inc`=1, `pc_load`=0; `retired`=1 after the edge; `rom_req`=1 in the following cycle.
- Jumps:
  - 0xE306 (D;JLE) with `ng`=1, `zr`=0 → `pc_load`=1, `pc_inc`=0.
  - 0xE306 with `ng`=0, `zr`=0 → `pc_inc`=1, `pc_load`=0.
  - 0xEA87 (0;JMP) → `pc_load`=1 regardless of flags.
- ROM wait: `rom_ack` arrives 3 cycles late → `rom_req` high 4 cycles; `instr` unchanged until the ack edge; spurious `rom_ack` in HALT does not change `instr`.
- Stall and wrap: `mem_busy` high for 2 EXEC cycles → `exec_en`, `pc_inc`, `pc_load` all 0 for 2 cycles, commit on the 3rd. Preset `retired` to 0xFFFF via 65535 commits (or force) → next commit gives 0x0000.
- Step and reset mid-op:
  - `step` pulse in HALT with `run`=0 → exactly one `exec_en` pulse, then `halted`=1.
  - `reset` asserted while `rom_req`=1 → `rom_req`=0 and `pc_reset`=1 in the same cycle; after release the controller reboots from BOOT.
